// File: rtl/rsa_job_arbiter_if.sv
// Job/core/response bus between the RSA job arbiter and its environment.
// slave = arbiter side, master = host + core side.
interface rsa_job_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 256,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ-1:0]       o_req_ready;
    logic [NREQ*WIDTH-1:0] i_req_a;
    logic [NREQ*WIDTH-1:0] i_req_d;
    logic [NREQ*WIDTH-1:0] i_req_n;
    logic                  o_core_start;
    logic [WIDTH-1:0]      o_core_a;
    logic [WIDTH-1:0]      o_core_d;
    logic [WIDTH-1:0]      o_core_n;
    logic [WIDTH-1:0]      i_core_result;
    logic                  i_core_finished;
    logic                  o_core_rst;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [WIDTH-1:0]      o_rsp_data;
    logic [IDW-1:0]        o_rsp_id;
    logic                  o_rsp_err;
    logic                  o_busy;

    modport slave (
        input  i_req_valid, i_req_a, i_req_d, i_req_n,
        input  i_core_result, i_core_finished, i_rsp_ready,
        output o_req_ready, o_core_start, o_core_a, o_core_d, o_core_n,
        output o_core_rst, o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_err, o_busy
    );

    modport master (
        output i_req_valid, i_req_a, i_req_d, i_req_n,
        output i_core_result, i_core_finished, i_rsp_ready,
        input  o_req_ready, o_core_start, o_core_a, o_core_d, o_core_n,
        input  o_core_rst, o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_err, o_busy
    );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one Rsa256Core between NREQ job sources.
// Optional watchdog on the core is enabled with `define RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter #(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 256,
    parameter int IDW            = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rsa_job_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

    state_t           state_reg, state_next;
    logic [IDW-1:0]   last_reg;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] a_reg, d_reg, n_reg;
    logic [WIDTH-1:0] data_reg;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             timeout_hit;
    logic             err_out;

    logic [WIDTH-1:0] a_slice [NREQ];
    logic [WIDTH-1:0] d_slice [NREQ];
    logic [WIDTH-1:0] n_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = bus.i_req_a[gi*WIDTH +: WIDTH];
            assign d_slice[gi] = bus.i_req_d[gi*WIDTH +: WIDTH];
            assign n_slice[gi] = bus.i_req_n[gi*WIDTH +: WIDTH];
        end
        if (NREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        end
    endgenerate

    // Scan from the farthest offset down so the requester nearest after last wins.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = (int'(last_reg) + i) % NREQ;
            if (bus.i_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 18) ? $clog2(TIMEOUT_CYCLES + 1) : 18;
    logic [CW-1:0] wdog_reg;
    logic          err_reg;

    // A finish in the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == ST_WAIT) && !bus.i_core_finished &&
                         (wdog_reg == CW'(TIMEOUT_CYCLES - 1));
    assign err_out     = err_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_LAUNCH)
                wdog_reg <= '0;
            else if (state_reg == ST_WAIT)
                wdog_reg <= wdog_reg + 1'b1;
            if (state_reg == ST_WAIT && bus.i_core_finished)
                err_reg <= 1'b0;
            else if (timeout_hit)
                err_reg <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_out     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        bus.o_req_ready  = '0;
        bus.o_core_start = 1'b0;
        bus.o_rsp_valid  = 1'b0;
        bus.o_busy       = (state_reg != ST_IDLE);
        bus.o_core_rst   = timeout_hit;
        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    bus.o_req_ready = NREQ'(1) << grant_idx;
                    state_next      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                bus.o_core_start = 1'b1;
                state_next       = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_core_finished || timeout_hit)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.o_rsp_valid = 1'b1;
                if (bus.i_rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands are captured only at accept, so the core sees them frozen for the whole job.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_reg <= IDW'(NREQ - 1);
            id_reg   <= '0;
            a_reg    <= '0;
            d_reg    <= '0;
            n_reg    <= '0;
            data_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && grant_found) begin
                last_reg <= grant_idx;
                id_reg   <= grant_idx;
                a_reg    <= a_slice[grant_idx];
                d_reg    <= d_slice[grant_idx];
                n_reg    <= n_slice[grant_idx];
            end
            if (state_reg == ST_WAIT && bus.i_core_finished)
                data_reg <= bus.i_core_result;
            else if (timeout_hit)
                data_reg <= '0;
        end
    end

    assign bus.o_core_a   = a_reg;
    assign bus.o_core_d   = d_reg;
    assign bus.o_core_n   = n_reg;
    assign bus.o_rsp_data = data_reg;
    assign bus.o_rsp_id   = id_reg;
    assign bus.o_rsp_err  = err_out;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: behavioural modexp core stub, round-robin reference model,
// directed plan steps followed by randomized jobs.
module tb_rsa_job_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;
    localparam int TOUT  = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]  req_valid = '0;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_d [NREQ];
    logic [WIDTH-1:0] op_n [NREQ];
    logic             rsp_ready = 1'b0;
    logic             stub_fin = 1'b0, spur_fin = 1'b0;
    logic [WIDTH-1:0] stub_res = '0, spur_res = '0;
    logic             kill_core = 1'b0, stub_dead = 1'b0;
    int               stub_lat = 0;
    time              fin_time = 0;

    int checks = 0;
    int errors = 0;
    int last_ref = NREQ - 1;

    rsa_job_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    rsa_job_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .TIMEOUT_CYCLES(TOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
            assign bus.i_req_a[gi*WIDTH +: WIDTH] = op_a[gi];
            assign bus.i_req_d[gi*WIDTH +: WIDTH] = op_d[gi];
            assign bus.i_req_n[gi*WIDTH +: WIDTH] = op_n[gi];
        end
    endgenerate
    assign bus.i_req_valid     = req_valid;
    assign bus.i_rsp_ready     = rsp_ready;
    assign bus.i_core_finished = stub_fin | spur_fin;
    assign bus.i_core_result   = stub_fin ? stub_res : spur_res;

    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] a, d, n);
        logic [63:0] r, b, m;
        m = 64'(n);
        r = 64'd1 % m;
        b = 64'(a) % m;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return WIDTH'(r);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int off = 1; off <= NREQ; off++)
            if (v[(last_ref + off) % NREQ]) return (last_ref + off) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core stub: computes a^d mod n from the operands it sees on the finish cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_core_start && !stub_dead) begin
                int lat;
                bit killed;
                lat = (stub_lat > 0) ? stub_lat : int'($urandom_range(1, 10));
                killed = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (kill_core) begin
                        killed = 1'b1;
                        break;
                    end
                end
                if (!killed) begin
                    stub_res = modexp(bus.o_core_a, bus.o_core_d, bus.o_core_n);
                    stub_fin = 1'b1;
                    fin_time = $time;
                    @(negedge clk);
                    stub_fin = 1'b0;
                end
            end
        end
    end

    task automatic set_op(input int k, input logic [WIDTH-1:0] a, d, n);
        op_a[k] = a;
        op_d[k] = d;
        op_n[k] = n;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            logic [WIDTH-1:0] n;
            n = WIDTH'($urandom_range(3, 65535)) | 1;
            set_op(k, WIDTH'($urandom_range(0, int'(n) - 1)), WIDTH'($urandom_range(1, 5000)), n);
        end
    endtask

    // Called just after a negedge, with the DUT idle.
    task automatic do_job(input logic [NREQ-1:0] v, input int bp, input bit scramble);
        int g, waited;
        logic [WIDTH-1:0] ea, ed, en, eres;
        req_valid = v;
        #1;
        g = rr_pick(v);
        chk("req_ready", 64'(bus.o_req_ready), 64'(1) << g);
        ea = op_a[g]; ed = op_d[g]; en = op_n[g];
        eres = modexp(ea, ed, en);
        @(negedge clk);
        last_ref = g;
        chk("core_start", 64'(bus.o_core_start), 64'd1);
        chk("core_a", 64'(bus.o_core_a), 64'(ea));
        chk("core_dn", {bus.o_core_d, bus.o_core_n}, {ed, en});
        chk("ready_busy", 64'(bus.o_req_ready), 64'd0);
        chk("core_rst_idle", 64'(bus.o_core_rst), 64'd0);
        if (scramble) rand_ops();
        @(negedge clk);
        chk("start_one_cycle", 64'(bus.o_core_start), 64'd0);
        waited = 0;
        while (!bus.o_rsp_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("rsp_valid_bound", 64'(bus.o_rsp_valid), 64'd1);
        chk("rsp_latency", 64'($time - fin_time), 64'd10);
        chk("rsp_data", 64'(bus.o_rsp_data), 64'(eres));
        chk("rsp_id_err", {bus.o_rsp_id, bus.o_rsp_err}, {IDW'(g), 1'b0});
        chk("core_a_hold", {bus.o_core_a, bus.o_core_n}, {ea, en});
        for (int i = 0; i < bp; i++) begin
            spur_res = WIDTH'($urandom);
            spur_fin = 1'b1;
            @(negedge clk);
            spur_fin = 1'b0;
            chk("bp_hold", {30'd0, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id, bus.o_rsp_data},
                {30'd1, 1'b0, IDW'(g), eres});
            chk("bp_ready", 64'(bus.o_req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_rsp", {bus.o_busy, bus.o_rsp_valid}, 2'b00);
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) set_op(k, '0, '0, 32'd1);
        #2;
        chk("reset_outputs", {bus.o_busy, bus.o_core_start, bus.o_rsp_valid, bus.o_req_ready,
                              bus.o_rsp_err, bus.o_core_rst}, 64'd0);
        chk("reset_data", {bus.o_rsp_data, bus.o_core_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job, then req0/req2 held valid continuously.
        set_op(0, 32'd2, 32'd7, 32'd143);
        do_job(4'b0001, 0, 1'b0);
        set_op(0, 32'd5, 32'd3, 32'd143);
        set_op(2, 32'd2, 32'd7, 32'd143);
        for (int j = 0; j < 4; j++) do_job(4'b0101, (j == 1) ? 10 : 0, 1'b0);
        chk("rr_direct_last", 64'(last_ref), 64'd0);

        // Operand changes during WAIT must not reach the core.
        do_job(4'b0100, 2, 1'b1);

        // Finish in IDLE is ignored.
        req_valid = '0;
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        chk("idle_finish_ignored", {bus.o_busy, bus.o_rsp_valid}, 2'b00);

        // Asynchronous reset in the middle of WAIT.
        stub_lat = 50;
        set_op(0, 32'd2, 32'd7, 32'd143);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        kill_core = 1'b1;
        #1;
        chk("async_rst_ctrl", {bus.o_busy, bus.o_core_start, bus.o_rsp_valid, bus.o_req_ready,
                               bus.o_rsp_id}, 64'd0);
        chk("async_rst_data", {bus.o_rsp_data, bus.o_core_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kill_core = 1'b0;
        stub_lat = 0;
        last_ref = NREQ - 1;
        set_op(1, 32'd5, 32'd3, 32'd143);
        do_job(4'b0010, 0, 1'b0);

`ifdef RSA_ARB_TIMEOUT_EN
        begin
            int waited;
            stub_dead = 1'b1;
            req_valid = 4'b1000;
            @(negedge clk);
            req_valid = '0;
            last_ref = 3;
            chk("to_start", 64'(bus.o_core_start), 64'd1);
            repeat (TOUT - 1) @(negedge clk);
            chk("to_rst_early", 64'(bus.o_core_rst), 64'd0);
            @(negedge clk);
            chk("to_rst_pulse", 64'(bus.o_core_rst), 64'd1);
            @(negedge clk);
            chk("to_rsp", {bus.o_core_rst, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id, bus.o_rsp_data},
                {1'b0, 1'b1, 1'b1, IDW'(3), WIDTH'(0)});
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            stub_dead = 1'b0;
            waited = 0;
            do_job(4'b0001, 0, 1'b0);
        end
`endif

        // Randomized jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            rand_ops();
            do_job(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
